// File: rtl/timer_8254_sequencer.sv
// Bus master for the 8254 timer: expands program / latch-and-read requests into
// three-byte CS_n/A/D/WR_n/RD_n transfers with programmable setup and strobe widths.
module timer_8254_sequencer #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        op,
    input  logic [1:0]  sel,
    input  logic [2:0]  mode,
    input  logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rd_value,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic [1:0]  A,
    output logic        WR_n,
    output logic        RD_n,
    output logic        CS_n
);

    localparam int unsigned PH_W   = 4;
    localparam int unsigned BYTE_W = 2;
    localparam logic [PH_W-1:0]   SETUP_LAST  = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0]   STROBE_LAST = PH_W'(STROBE_CYCLES - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST   = BYTE_W'(2);
    localparam logic [1:0]        SEL_BAD     = 2'd3;
    localparam logic [1:0]        A_CTRL      = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              op_q;
    logic [1:0]        sel_q;
    logic [2:0]        mode_q;
    logic [15:0]       count_q;
    logic [7:0]        lsb_q, msb_q;

    logic              wr_byte, rd_capture;
    logic [7:0]        tx_data;
    logic [1:0]        tx_addr;
    logic              busy_d, done_d, err_d, d_oe_d, wr_n_d, rd_n_d, cs_n_d;
    logic [15:0]       rd_value_d;
    logic [7:0]        d_out_d;
    logic [1:0]        a_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            byte_q  <= byte_d;
        end
    end

    // Request fields are latched on accept; read bytes are captured at the end of their strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q    <= 1'b0;
            sel_q   <= '0;
            mode_q  <= '0;
            count_q <= '0;
            lsb_q   <= '0;
            msb_q   <= '0;
        end else begin
            if (state_q == S_IDLE && req) begin
                op_q    <= op;
                sel_q   <= sel;
                mode_q  <= mode;
                count_q <= count;
            end
            if (rd_capture) begin
                if (byte_q == BYTE_W'(1)) lsb_q <= D_in;
                else                      msb_q <= D_in;
            end
        end
    end

    // Pins are registered from the decoded state, so they trail the state by one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_value <= '0;
            D_out    <= '0;
            D_oe     <= 1'b0;
            A        <= '0;
            WR_n     <= 1'b1;
            RD_n     <= 1'b1;
            CS_n     <= 1'b1;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            rd_value <= rd_value_d;
            D_out    <= d_out_d;
            D_oe     <= d_oe_d;
            A        <= a_d;
            WR_n     <= wr_n_d;
            RD_n     <= rd_n_d;
            CS_n     <= cs_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_d     = byte_q;
        rd_capture = 1'b0;
        busy_d     = (state_q != S_IDLE);
        done_d     = 1'b0;
        err_d      = 1'b0;
        cs_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        d_oe_d     = 1'b0;
        a_d        = A;
        d_out_d    = D_out;
        rd_value_d = rd_value;

        // Byte 0 is always the control/latch write; reads use bytes 1 and 2.
        wr_byte = !op_q || (byte_q == '0);
        tx_addr = (byte_q == '0) ? A_CTRL : sel_q;
        if (byte_q == '0)
            tx_data = op_q ? {sel_q, 6'b000000} : {sel_q, 2'b11, mode_q, 1'b0};
        else if (byte_q == BYTE_W'(1))
            tx_data = count_q[7:0];
        else
            tx_data = count_q[15:8];

        if (state_q == S_SETUP || state_q == S_STROBE || state_q == S_HOLD) begin
            cs_n_d  = 1'b0;
            a_d     = tx_addr;
            d_out_d = tx_data;
            d_oe_d  = wr_byte;
        end

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = (sel == SEL_BAD) ? S_DONE : S_SETUP;
                    phase_d = '0;
                    byte_d  = '0;
                end
            end
            S_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_STROBE: begin
                wr_n_d = !wr_byte;
                rd_n_d = wr_byte;
                if (phase_q == STROBE_LAST) begin
                    state_d = S_HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_HOLD: begin
                rd_capture = !wr_byte;
                if (byte_q == BYTE_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETUP;
                    byte_d  = byte_q + BYTE_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                err_d   = (sel_q == SEL_BAD);
                state_d = S_IDLE;
                if (op_q && sel_q != SEL_BAD) rd_value_d = {msb_q, lsb_q};
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_timer_8254_sequencer.sv
// Bench for timer_8254_sequencer: two instances (default timing and SETUP=3/STROBE=1)
// checked every cycle against a timeline model, plus literal byte/latency expectations.
module tb_timer_8254_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req, op;
    logic [1:0]  sel;
    logic [2:0]  mode;
    logic [15:0] count;

    logic        busy[2], done[2], err[2], doe[2], wrn[2], rdn[2], csn[2];
    logic [15:0] rdv[2];
    logic [7:0]  dout[2], din[2];
    logic [1:0]  a[2];

    logic [7:0]  rd_lsb = 8'h00;
    logic [7:0]  rd_msb = 8'h00;
    logic        chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    timer_8254_sequencer #(.SETUP_CYCLES(1), .STROBE_CYCLES(2)) u_dut0 (
        .CLK(CLK), .RST(RST), .req(req), .op(op), .sel(sel), .mode(mode), .count(count),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .rd_value(rdv[0]),
        .D_out(dout[0]), .D_oe(doe[0]), .D_in(din[0]), .A(a[0]),
        .WR_n(wrn[0]), .RD_n(rdn[0]), .CS_n(csn[0])
    );

    timer_8254_sequencer #(.SETUP_CYCLES(3), .STROBE_CYCLES(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .req(req), .op(op), .sel(sel), .mode(mode), .count(count),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .rd_value(rdv[1]),
        .D_out(dout[1]), .D_oe(doe[1]), .D_in(din[1]), .A(a[1]),
        .WR_n(wrn[1]), .RD_n(rdn[1]), .CS_n(csn[1])
    );

    initial forever #5 CLK = ~CLK;

    function automatic int s_cyc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int t_cyc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Offset from accept edge to the visible done cycle.
    function automatic int op_len(input int i, input logic [1:0] s);
        return (s == 2'd3) ? 1 : 3 * (s_cyc(i) + t_cyc(i) + 1) + 1;
    endfunction

    // Bus monitor: logs write bytes, read addresses and counts read pulses / CS cycles.
    int          wr_cnt[2]  = '{0, 0};
    int          rd_cnt[2]  = '{0, 0};
    int          rd_rise[2] = '{0, 0};
    int          cs_cnt[2]  = '{0, 0};
    logic        prev_wr[2] = '{1'b1, 1'b1};
    logic        prev_rd[2] = '{1'b1, 1'b1};
    logic [9:0]  wr_log[2][64];
    logic [1:0]  rd_log[2][64];

    assign din[0] = rd_rise[0][0] ? rd_msb : rd_lsb;
    assign din[1] = rd_rise[1][0] ? rd_msb : rd_lsb;

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            prev_wr[i] <= wrn[i];
            prev_rd[i] <= rdn[i];
            if (!wrn[i] && prev_wr[i]) begin
                wr_log[i][wr_cnt[i][5:0]] <= {a[i], dout[i]};
                wr_cnt[i] <= wr_cnt[i] + 1;
            end
            if (!rdn[i] && prev_rd[i]) begin
                rd_log[i][rd_cnt[i][5:0]] <= a[i];
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
            if (rdn[i] && !prev_rd[i]) rd_rise[i] <= rd_rise[i] + 1;
            if (!csn[i]) cs_cnt[i] <= cs_cnt[i] + 1;
        end
    end

    // Model: tracks accepts and the committed read value per instance.
    int          cyc = 0;
    logic        m_act[2] = '{1'b0, 1'b0};
    int          m_start[2] = '{0, 0};
    logic        m_op[2];
    logic [1:0]  m_sel[2];
    logic [2:0]  m_mode[2];
    logic [15:0] m_count[2];
    logic [15:0] m_rdv[2] = '{16'h0, 16'h0};

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0;
                m_rdv[i] <= 16'h0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (m_act[i] && (cyc + 1 - m_start[i]) == op_len(i, m_sel[i])
                    && m_op[i] && m_sel[i] != 2'd3)
                    m_rdv[i] <= {rd_msb, rd_lsb};
                if ((!m_act[i] || (cyc + 1 - m_start[i]) > op_len(i, m_sel[i])) && req) begin
                    m_act[i]   <= 1'b1;
                    m_start[i] <= cyc + 1;
                    m_op[i]    <= op;
                    m_sel[i]   <= sel;
                    m_mode[i]  <= mode;
                    m_count[i] <= count;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int s, t, p, len, r, b, ph;
            logic bus, strobe, wr, e_done, e_err;
            logic [1:0] ea;
            logic [7:0] ed;
            s = s_cyc(i); t = t_cyc(i); p = s + t + 1;
            len = op_len(i, m_sel[i]);
            r = cyc - m_start[i];
            bus = 1'b0; strobe = 1'b0; wr = 1'b0; e_done = 1'b0; e_err = 1'b0;
            ea = 2'b00; ed = 8'h00; b = 0; ph = 0;
            if (m_act[i] && r >= 1 && r < len) begin
                bus = 1'b1;
                b = (r - 1) / p;
                ph = (r - 1) % p;
                wr = !m_op[i] || b == 0;
                strobe = (ph >= s) && (ph < s + t);
                ea = (b == 0) ? 2'b11 : m_sel[i];
                case (b)
                    0:       ed = m_op[i] ? {m_sel[i], 6'b000000} : {m_sel[i], 2'b11, m_mode[i], 1'b0};
                    1:       ed = m_count[i][7:0];
                    default: ed = m_count[i][15:8];
                endcase
            end
            if (m_act[i] && r == len) begin
                e_done = 1'b1;
                e_err = (m_sel[i] == 2'd3);
            end
            chk($sformatf("u%0d.busy r=%0d", i, r), 32'(busy[i]), 32'(bus | e_done));
            chk($sformatf("u%0d.done r=%0d", i, r), 32'(done[i]), 32'(e_done));
            chk($sformatf("u%0d.err r=%0d", i, r), 32'(err[i]), 32'(e_err));
            chk($sformatf("u%0d.CS_n r=%0d", i, r), 32'(csn[i]), 32'(!bus));
            chk($sformatf("u%0d.WR_n r=%0d", i, r), 32'(wrn[i]), 32'(!(strobe && wr)));
            chk($sformatf("u%0d.RD_n r=%0d", i, r), 32'(rdn[i]), 32'(!(strobe && !wr)));
            chk($sformatf("u%0d.D_oe r=%0d", i, r), 32'(doe[i]), 32'(bus && wr));
            chk($sformatf("u%0d.rd_value r=%0d", i, r), 32'(rdv[i]), 32'(m_rdv[i]));
            if (bus) chk($sformatf("u%0d.A r=%0d", i, r), 32'(a[i]), 32'(ea));
            if (bus && wr) chk($sformatf("u%0d.D_out r=%0d", i, r), 32'(dout[i]), 32'(ed));
            chk($sformatf("u%0d.strobe_overlap", i), 32'(wrn[i] | rdn[i]), 32'd1);
            chk($sformatf("u%0d.strobe_without_cs", i), 32'(csn[i] & ~(wrn[i] & rdn[i])), 32'd0);
        end
    endtask

    int lat[2], wbase[2], rbase[2], cbase[2], nd[2];

    task automatic run_op(input logic o, input logic [1:0] s, input logic [2:0] m,
                          input logic [15:0] c);
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            wbase[i] = wr_cnt[i]; rbase[i] = rd_cnt[i]; cbase[i] = cs_cnt[i]; lat[i] = -1;
        end
        op = o; sel = s; mode = m; count = c; req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        for (int n = 1; n <= 40 && (lat[0] < 0 || lat[1] < 0); n++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) if (done[i] && lat[i] < 0) lat[i] = n;
        end
        @(negedge CLK);
    endtask

    task automatic chk_wr(input int i, input int j, input logic [9:0] exp);
        chk($sformatf("u%0d.wr_byte%0d", i, j), 32'(wr_log[i][6'(wbase[i] + j)]), 32'(exp));
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge CLK);
                    if (chk_en) compare_all();
                end
            end
            begin
                RST = 1'b1; req = 1'b0; op = 1'b0; sel = 2'd0; mode = 3'd0; count = 16'h0;
                repeat (3) @(negedge CLK);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d.reset_ctl", i),
                        32'({busy[i], done[i], err[i], doe[i], wrn[i], rdn[i], csn[i]}), 32'b0000111);
                    chk($sformatf("u%0d.reset_bus", i), 32'({a[i], dout[i]}), 32'd0);
                    chk($sformatf("u%0d.reset_rd_value", i), 32'(rdv[i]), 32'd0);
                end
                RST = 1'b0;
                chk_en = 1'b1;

                // Program sel=1 mode=3 count=1234
                run_op(1'b0, 2'd1, 3'd3, 16'h1234);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d.prog_latency", i), 32'(lat[i]), (i == 0) ? 32'd13 : 32'd16);
                    chk($sformatf("u%0d.prog_nwrites", i), 32'(wr_cnt[i] - wbase[i]), 32'd3);
                    chk_wr(i, 0, {2'b11, 8'h76});
                    chk_wr(i, 1, {2'b01, 8'h34});
                    chk_wr(i, 2, {2'b01, 8'h12});
                end

                // Latch-and-read sel=2, timer returns CD then AB
                rd_lsb = 8'hCD; rd_msb = 8'hAB;
                run_op(1'b1, 2'd2, 3'd0, 16'h0);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d.read_latency", i), 32'(lat[i]), (i == 0) ? 32'd13 : 32'd16);
                    chk($sformatf("u%0d.read_nwrites", i), 32'(wr_cnt[i] - wbase[i]), 32'd1);
                    chk_wr(i, 0, {2'b11, 8'h80});
                    chk($sformatf("u%0d.read_npulses", i), 32'(rd_cnt[i] - rbase[i]), 32'd2);
                    chk($sformatf("u%0d.read_addr0", i), 32'(rd_log[i][6'(rbase[i])]), 32'd2);
                    chk($sformatf("u%0d.read_addr1", i), 32'(rd_log[i][6'(rbase[i] + 1)]), 32'd2);
                    chk($sformatf("u%0d.read_value", i), 32'(rdv[i]), 32'hABCD);
                end

                // Illegal sel=3 read: no bus cycle, immediate done+err, value kept
                rd_lsb = 8'h11; rd_msb = 8'h22;
                run_op(1'b1, 2'd3, 3'd0, 16'h0);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d.bad_latency", i), 32'(lat[i]), 32'd1);
                    chk($sformatf("u%0d.bad_cs_cycles", i), 32'(cs_cnt[i] - cbase[i]), 32'd0);
                    chk($sformatf("u%0d.bad_rd_value", i), 32'(rdv[i]), 32'hABCD);
                end

                // Program sel=0 mode=2 count=0
                run_op(1'b0, 2'd0, 3'd2, 16'h0000);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d.zero_latency", i), 32'(lat[i]), (i == 0) ? 32'd13 : 32'd16);
                    chk_wr(i, 0, {2'b11, 8'h34});
                    chk_wr(i, 1, {2'b00, 8'h00});
                    chk_wr(i, 2, {2'b00, 8'h00});
                end

                // req held high for 42 edges: back-to-back accepts only after each done
                @(negedge CLK);
                for (int i = 0; i < 2; i++) begin wbase[i] = wr_cnt[i]; nd[i] = 0; end
                op = 1'b0; sel = 2'd2; mode = 3'd1; count = 16'h5A5A; req = 1'b1;
                for (int n = 0; n < 42; n++) begin
                    @(negedge CLK);
                    for (int i = 0; i < 2; i++) if (done[i]) nd[i]++;
                end
                req = 1'b0;
                repeat (25) @(negedge CLK);
                chk("u0.b2b_done_pulses", 32'(nd[0]), 32'd3);
                chk("u1.b2b_done_pulses", 32'(nd[1]), 32'd2);
                chk("u0.b2b_nwrites", 32'(wr_cnt[0] - wbase[0]), 32'd9);
                chk("u1.b2b_nwrites", 32'(wr_cnt[1] - wbase[1]), 32'd9);

                // Reset during byte-1 strobe of u0 aborts both transfers at once
                @(negedge CLK);
                op = 1'b0; sel = 2'd1; mode = 3'd0; count = 16'h7777; req = 1'b1;
                @(negedge CLK);
                req = 1'b0;
                repeat (6) @(negedge CLK);
                chk("u0.pre_abort_WR_n", 32'(wrn[0]), 32'd0);
                chk("u1.pre_abort_CS_n", 32'(csn[1]), 32'd0);
                #2 RST = 1'b1;
                #1;
                for (int i = 0; i < 2; i++)
                    chk($sformatf("u%0d.abort_pins", i),
                        32'({wrn[i], rdn[i], csn[i], doe[i], busy[i]}), 32'b11100);
                repeat (2) @(negedge CLK);
                RST = 1'b0;
                for (int i = 0; i < 2; i++)
                    chk($sformatf("u%0d.abort_rd_value", i), 32'(rdv[i]), 32'd0);

                run_op(1'b0, 2'd2, 3'd0, 16'hBEEF);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d.post_latency", i), 32'(lat[i]), (i == 0) ? 32'd13 : 32'd16);
                    chk_wr(i, 0, {2'b11, 8'hB0});
                    chk_wr(i, 1, {2'b10, 8'hEF});
                    chk_wr(i, 2, {2'b10, 8'hBE});
                end
                repeat (3) @(negedge CLK);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
